// File: rtl/aes_decipher_block.sv
// Iterative AES-128/256 decryption datapath: InvShiftRows, word-serial InvSubBytes through an
// external inverse S-box, then AddRoundKey + InvMixColumns, with round keys from the key memory.
module aes_decipher_block #(
  parameter int unsigned AES_128_NR = 10,
  parameter int unsigned AES_256_NR = 14
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  typedef enum logic [2:0] {StIdle, StInit, StShift, StSbox, StAddMix} state_e;

  localparam logic [3:0] Nr128 = 4'(AES_128_NR);
  localparam logic [3:0] Nr256 = 4'(AES_256_NR);

  state_e       state_q, state_d;
  logic [127:0] block_q, block_d;
  logic [3:0]   round_q, round_d;
  logic [1:0]   sword_q, sword_d;
  logic         keylen_q, keylen_d;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse MixColumns on one column; 0e/0b/0d/09 built from shared x2/x4/x8 terms.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] m2, m4, m8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = w[31-8*i -: 8];
      m2    = xt(a[i]);
      m4    = xt(m2);
      m8    = xt(m4);
      m9[i] = m8 ^ a[i];
      mb[i] = m8 ^ m2 ^ a[i];
      md[i] = m8 ^ m4 ^ a[i];
      me[i] = m8 ^ m4 ^ m2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  // Byte (r,c) sits at index 4c+r; row r rotates right by r columns.
  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      block_q  <= '0;
      round_q  <= '0;
      sword_q  <= '0;
      keylen_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      block_q  <= block_d;
      round_q  <= round_d;
      sword_q  <= sword_d;
      keylen_q <= keylen_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    block_d  = block_q;
    round_d  = round_q;
    sword_d  = sword_q;
    keylen_d = keylen_q;
    unique case (state_q)
      StIdle: begin
        if (next) begin
          keylen_d = keylen;
          round_d  = keylen ? Nr256 : Nr128;
          state_d  = StInit;
        end
      end
      StInit: begin
        block_d = block ^ round_key;
        round_d = (keylen_q ? Nr256 : Nr128) - 4'd1;
        state_d = StShift;
      end
      StShift: begin
        block_d = inv_shift(block_q);
        sword_d = 2'd0;
        state_d = StSbox;
      end
      StSbox: begin
        unique case (sword_q)
          2'd0: block_d[127:96] = new_sboxw;
          2'd1: block_d[95:64]  = new_sboxw;
          2'd2: block_d[63:32]  = new_sboxw;
          2'd3: block_d[31:0]   = new_sboxw;
          default: ;
        endcase
        sword_d = sword_q + 2'd1;
        if (sword_q == 2'd3) begin
          state_d = StAddMix;
        end
      end
      StAddMix: begin
        if (round_q != 4'd0) begin
          block_d = inv_mix(block_q ^ round_key);
          round_d = round_q - 4'd1;
          state_d = StShift;
        end else begin
          block_d = block_q ^ round_key;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sboxw = '0;
    ready = (state_q == StIdle);
    if (state_q == StSbox) begin
      unique case (sword_q)
        2'd0: sboxw = block_q[127:96];
        2'd1: sboxw = block_q[95:64];
        2'd2: sboxw = block_q[63:32];
        2'd3: sboxw = block_q[31:0];
        default: sboxw = '0;
      endcase
    end
  end

  assign new_block = block_q;
  assign round     = round_q;

endmodule

// File: tb/tb_aes_decipher_block.sv
// Bench for aes_decipher_block: algorithmic AES model (S-box derived from GF(2^8) inverses),
// key memory and inverse S-box driven from the model, per-cycle schedule/output comparison.
module tb_aes_decipher_block;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb  [0:255];
  logic [7:0]   isb [0:255];
  logic [127:0] rk  [0:15];

  always #5 clk = ~clk;

  aes_decipher_block dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .next      (next),
    .keylen    (keylen),
    .round     (round),
    .round_key (round_key),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw),
    .block     (block),
    .new_block (new_block),
    .ready     (ready)
  );

  assign round_key = rk[round];
  assign new_sboxw = {isb[sboxw[31:24]], isb[sboxw[23:16]], isb[sboxw[15:8]], isb[sboxw[7:0]]};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] t = {b, b};
    t = t << k;
    return t[15:8];
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int r, input int c);
    return s[127-8*(4*c+r) -: 8];
  endfunction

  function automatic logic [127:0] pb(input logic [127:0] s, input int r, input int c,
                                     input logic [7:0] v);
    s[127-8*(4*c+r) -: 8] = v;
    return s;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
    for (int i = 0; i < 16; i++) begin
      s[127-8*i -: 8] = inv ? isb[s[127-8*i -: 8]] : sb[s[127-8*i -: 8]];
    end
    return s;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
    logic [127:0] o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o = pb(o, r, c, gb(s, r, inv ? (c + 4 - r) % 4 : (c + r) % 4));
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
    logic [31:0]  mc = inv ? 32'h0e0b0d09 : 32'h02030101;
    logic [127:0] o  = '0;
    logic [7:0]   v;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        v = 8'h00;
        for (int k = 0; k < 4; k++) v ^= gmul(mc[31-8*((k+4-r)%4) -: 8], gb(s, k, c));
        o = pb(o, r, c, v);
      end
    return o;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt, input int nr);
    logic [127:0] s = pt ^ rk[0];
    for (int r = 1; r <= nr; r++) begin
      s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
      if (r < nr) s = mix_cols(s, 1'b0);
      s ^= rk[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] dec(input logic [127:0] ct, input int nr);
    logic [127:0] s = ct ^ rk[nr];
    for (int r = nr - 1; r >= 0; r--) begin
      s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[r];
      if (r > 0) s = mix_cols(s, 1'b1);
    end
    return s;
  endfunction

  // State presented to InvSubBytes during decryption round rnd.
  function automatic logic [127:0] pre_sbox(input logic [127:0] ct, input int nr, input int rnd);
    logic [127:0] s = ct ^ rk[nr];
    for (int r = nr - 1; r >= 0; r--) begin
      s = shift_rows(s, 1'b1);
      if (r == rnd) return s;
      s = sub_bytes(s, 1'b1) ^ rk[r];
      if (r > 0) s = mix_cols(s, 1'b1);
    end
    return s;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  task automatic expand(input logic [255:0] key, input logic kl);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int nk = kl ? 8 : 4;
    int nr = kl ? 14 : 10;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = {t[23:0], t[31:24]};
          t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r < 16; r++) rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  // Cycle-level expectation: busy for 1 + 6*Nr cycles after an accepted next.
  logic         m_busy;
  int           m_t;
  int           m_nr;
  logic [127:0] m_ct;
  logic [127:0] m_out;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0;
      m_t    <= 0;
      m_nr   <= 10;
      m_ct   <= '0;
      m_out  <= '0;
    end else if (!m_busy) begin
      if (next) begin
        m_busy <= 1'b1;
        m_t    <= 0;
        m_nr   <= keylen ? 14 : 10;
      end
    end else begin
      if (m_t == 0) m_ct <= block;
      if (m_t == 6 * m_nr) begin
        m_busy <= 1'b0;
        m_out  <= dec(m_ct, m_nr);
      end
      m_t <= m_t + 1;
    end
  end

  always @(negedge clk) begin
    int exp_round, p;
    logic [127:0] s;
    logic [31:0]  exp_sw;
    if (reset_n) begin
      chk("ready", 128'(ready), 128'(!m_busy));
      if (!m_busy) begin
        chk("new_block idle", new_block, m_out);
        chk("round idle", 128'(round), 128'd0);
        chk("sboxw idle", 128'(sboxw), 128'd0);
      end else begin
        exp_round = (m_t == 0) ? m_nr : m_nr - 1 - (m_t - 1) / 6;
        p = (m_t - 1) % 6;
        exp_sw = 32'h0;
        if (m_t > 0 && p >= 1 && p <= 4) begin
          s = pre_sbox(m_ct, m_nr, exp_round);
          exp_sw = s[127-32*(p-1) -: 32];
        end
        chk("round busy", 128'(round), 128'(exp_round));
        chk("sboxw busy", 128'(sboxw), 128'(exp_sw));
      end
    end
  end

  task automatic run(input logic [127:0] ct, input logic kl, input bit disturb, output int lat);
    block  = ct;
    keylen = kl;
    next   = 1'b1;
    @(negedge clk);
    next = 1'b0;
    lat  = 0;
    while (!ready && lat < 200) begin
      @(negedge clk);
      lat++;
      if (disturb) begin
        next = (lat == 5 || lat == 30);
        if (lat == 15) keylen = ~keylen;
      end
    end
    next = 1'b0;
  endtask

  localparam logic [255:0] Key128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] Key256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] Pt     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Ct128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Ct256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    int lat;
    logic [255:0] key;
    logic [127:0] pt, ct;
    logic kl;
    reset_n = 1'b0;
    next    = 1'b0;
    keylen  = 1'b0;
    block   = '0;
    build_sbox();
    expand(Key128, 1'b0);
    chk("model sbox 00", 128'(sb[0]), 128'h63);
    chk("model sbox 53", 128'(sb[8'h53]), 128'hed);
    chk("model isbox 00", 128'(isb[0]), 128'h52);
    chk("model enc C1", enc(Pt, 10), Ct128);
    chk("model dec C1", dec(Ct128, 10), Pt);
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", 128'(ready), 128'd1);
    chk("reset new_block", new_block, 128'd0);
    chk("reset round", 128'(round), 128'd0);
    chk("reset sboxw", 128'(sboxw), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run(Ct128, 1'b0, 1'b0, lat);
    chk("C1 plaintext", new_block, Pt);
    chk("C1 latency", 128'(lat), 128'd61);

    expand(Key256, 1'b1);
    chk("model dec C3", dec(Ct256, 14), Pt);
    run(Ct256, 1'b1, 1'b0, lat);
    chk("C3 plaintext", new_block, Pt);
    chk("C3 latency", 128'(lat), 128'd85);

    expand(Key128, 1'b0);
    run(Ct128, 1'b0, 1'b1, lat);
    chk("busy plaintext", new_block, Pt);
    chk("busy latency", 128'(lat), 128'd61);
    run(Ct128, 1'b0, 1'b0, lat);
    chk("b2b plaintext", new_block, Pt);
    chk("b2b latency", 128'(lat), 128'd61);

    block  = Ct128;
    keylen = 1'b0;
    next   = 1'b1;
    @(negedge clk);
    next = 1'b0;
    repeat (19) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset ready", 128'(ready), 128'd1);
    chk("midreset new_block", new_block, 128'd0);
    chk("midreset round", 128'(round), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run(Ct128, 1'b0, 1'b0, lat);
    chk("post-reset plaintext", new_block, Pt);
    chk("post-reset latency", 128'(lat), 128'd61);

    for (int i = 0; i < 100; i++) begin
      kl  = 1'(i % 2);
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand(key, kl);
      ct = enc(pt, kl ? 14 : 10);
      run(ct, kl, 1'b0, lat);
      chk("roundtrip plaintext", new_block, pt);
      chk("roundtrip latency", 128'(lat), kl ? 128'd85 : 128'd61);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
